// File: rtl/layer_norm_if.sv
// Vector bus for layer_norm: unsigned input vector in, signed fixed-point
// normalized vector plus valid out.
interface layer_norm_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] input_vector      [0:N-1];
  logic [DATA_WIDTH-1:0] normalized_vector [0:N-1];
  logic                  out_valid;

  modport master (output input_vector, input normalized_vector, input out_valid);
  modport slave  (input input_vector, output normalized_vector, output out_valid);
endinterface

// File: rtl/layer_norm.sv
// Single-cycle layer normalization: mean, variance, integer sqrt and divide in one
// combinational pass, result registered. Optional LAYERNORM_ROUND_NEAREST_EN rounds the divide.
module layer_norm #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  layer_norm_if.slave  bus
);
  localparam int LOG2N = $clog2(N);
  localparam int SUMW  = DATA_WIDTH + LOG2N;
  localparam int DW1   = DATA_WIDTH + 1;
  localparam int SQW   = 2 * DW1;
  localparam int ACCW  = SQW + LOG2N;
  // one spare bit so the rounding bias never overflows the numerator
  localparam int QW    = DW1 + FRAC_BITS + 1;
  localparam logic [QW-1:0] POS_MAX = QW'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic [QW-1:0] NEG_MAG = QW'(1 << (DATA_WIDTH-1));

  logic [SUMW-1:0]        sum;
  logic [DATA_WIDTH-1:0]  mean;
  logic signed [DW1-1:0]  d [0:N-1];
  logic signed [SQW-1:0]  dx, sq;
  logic [ACCW-1:0]        acc;
  logic [SQW-1:0]         variance;
  logic [DW1-1:0]         std_v, cand;
  logic [DW1-1:0]         absd;
  logic [QW-1:0]          num, den, q;

  logic [DATA_WIDTH-1:0]  norm_d [0:N-1];
  logic [DATA_WIDTH-1:0]  norm_q [0:N-1];
  logic                   out_valid_d, out_valid_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + SUMW'(bus.input_vector[i]);
    mean = sum[SUMW-1:LOG2N];

    acc = '0;
    dx  = '0;
    sq  = '0;
    for (int i = 0; i < N; i++) begin
      d[i] = $signed({1'b0, bus.input_vector[i]}) - $signed({1'b0, mean});
      dx   = SQW'(d[i]);
      sq   = dx * dx;
      acc  = acc + ACCW'($unsigned(sq));
    end
    variance = acc[ACCW-1:LOG2N];

    // bitwise integer sqrt: keep each root bit whose square still fits
    std_v = '0;
    cand  = '0;
    for (int b = DW1-1; b >= 0; b--) begin
      cand = std_v | (DW1'(1) << b);
      if ((SQW'(cand) * SQW'(cand)) <= variance) std_v = cand;
    end
  end

  always_comb begin
    out_valid_d = 1'b1;
    absd = '0;
    num  = '0;
    q    = '0;
    den  = (std_v == '0) ? QW'(1) : QW'(std_v);
    for (int i = 0; i < N; i++) begin
      norm_d[i] = '0;
      // divide magnitudes so truncation/rounding is symmetric about zero
      absd = d[i][DW1-1] ? $unsigned(-d[i]) : $unsigned(d[i]);
      num  = QW'(absd) << FRAC_BITS;
`ifdef LAYERNORM_ROUND_NEAREST_EN
      num  = num + QW'(std_v >> 1);
`endif
      q = num / den;
      if (std_v != '0) begin
        if (d[i][DW1-1])
          norm_d[i] = (q > NEG_MAG) ? DATA_WIDTH'(NEG_MAG) : DATA_WIDTH'(-q);
        else
          norm_d[i] = (q > POS_MAX) ? DATA_WIDTH'(POS_MAX) : DATA_WIDTH'(q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) norm_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      norm_q      <= norm_d;
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.normalized_vector = norm_q;
endmodule

// File: tb/tb_layer_norm.sv
// Bench for layer_norm (N=4): directed table, reset corner sequences and
// randomized vectors checked against an arithmetic reference model.
module tb_layer_norm;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int FB = 4;

  typedef int vec_t [0:N-1];
  typedef struct {
    string nm;
    vec_t  x;
    vec_t  y;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  layer_norm_if #(.N(N), .DATA_WIDTH(DW)) bus ();
  layer_norm #(.N(N), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t model(input vec_t x);
    vec_t y;
    int s, mean, v, sd, dd, q;
    int d [0:N-1];
    s = 0;
    foreach (x[i]) s += x[i];
    mean = s / N;
    v = 0;
    foreach (x[i]) begin d[i] = x[i] - mean; v += d[i] * d[i]; end
    v = v / N;
    sd = 0;
    while ((sd + 1) * (sd + 1) <= v) sd++;
    foreach (x[i]) begin
      if (sd == 0) y[i] = 0;
      else begin
`ifdef LAYERNORM_ROUND_NEAREST_EN
        dd = (d[i] < 0) ? -d[i] : d[i];
        q  = (dd * (1 << FB) + sd / 2) / sd;
        if (d[i] < 0) q = -q;
`else
        q = (d[i] * (1 << FB)) / sd;
`endif
        if (q > (1 << (DW-1)) - 1) q = (1 << (DW-1)) - 1;
        if (q < -(1 << (DW-1)))    q = -(1 << (DW-1));
        y[i] = q;
      end
    end
    return y;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    @(negedge clk);
    foreach (x[i]) bus.input_vector[i] = 8'(x[i]);
  endtask

  task automatic sample_check(input string nm, input logic vld, input vec_t y);
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, int'(bus.out_valid), int'(vld));
    foreach (y[i]) chk($sformatf("%s[%0d]", nm, i), int'($signed(bus.normalized_vector[i])), y[i]);
  endtask

  row_t tbl [6];
  vec_t zero, xv;

  initial begin
    zero = '{0, 0, 0, 0};
    tbl[0] = '{"ramp",  '{10, 20, 30, 40},
`ifdef LAYERNORM_ROUND_NEAREST_EN
               '{-22, -7, 7, 22}};
`else
               '{-21, -7, 7, 21}};
`endif
    tbl[1] = '{"rramp", '{40, 30, 20, 10},
`ifdef LAYERNORM_ROUND_NEAREST_EN
               '{22, 7, -7, -22}};
`else
               '{21, 7, -7, -21}};
`endif
    tbl[2] = '{"flat",  '{50, 50, 50, 50}, '{0, 0, 0, 0}};
    tbl[3] = '{"spike", '{0, 0, 0, 255},
`ifdef LAYERNORM_ROUND_NEAREST_EN
               '{-9, -9, -9, 28}};
`else
               '{-9, -9, -9, 27}};
`endif
    tbl[4] = '{"ramp2", '{10, 20, 30, 40},
`ifdef LAYERNORM_ROUND_NEAREST_EN
               '{-22, -7, 7, 22}};
`else
               '{-21, -7, 7, 21}};
`endif
    tbl[5] = '{"tiny",  '{0, 0, 0, 2}, '{0, 0, 0, 32}};

    // reset held for two edges with non-zero input
    rst = 1'b1;
    drive('{7, 99, 200, 3});
    sample_check("rst0", 1'b0, zero);
    sample_check("rst1", 1'b0, zero);

    // table rows on consecutive edges: back-to-back, no bubbles
    drive(tbl[0].x);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      sample_check(tbl[r].nm, 1'b1, tbl[r].y);
      if (r < 5) drive(tbl[r+1].x);
    end

    // reset for one edge mid-stream, then recovery on the next input
    drive('{40, 30, 20, 10});
    rst = 1'b1;
    sample_check("midrst", 1'b0, zero);
    drive(tbl[3].x);
    rst = 1'b0;
    sample_check("recover", 1'b1, tbl[3].y);

    // randomized: full range mixed with narrow ranges for tiny/zero std
    for (int k = 0; k < 300; k++) begin
      foreach (xv[i]) xv[i] = (k % 3 == 0) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 255));
      if (k % 17 == 0) foreach (xv[i]) xv[i] = xv[0];
      drive(xv);
      sample_check($sformatf("rnd%0d", k), 1'b1, model(xv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_norm.md
Name: layer_norm

Overview:
Single-vector layer-normalization block. Each clock it samples an N-element unsigned input vector, computes mean, variance and integer standard deviation, and registers the signed fixed-point normalized vector. It feeds downstream transformer datapath stages that expect one normalized vector per cycle, with a fixed 1-cycle latency and no backpressure.

Parameters:
N, 4, vector length; must be a power of two, 2..16 (divide-by-N is a right shift by log2(N)).
DATA_WIDTH, 8, width of every input and output element.
FRAC_BITS, 4, fractional bits of the signed output format; must be less than DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
input_vector  input  N x DATA_WIDTH (unpacked array [0:N-1])  unsigned input elements.
normalized_vector  output  N x DATA_WIDTH (unpacked array [0:N-1])  signed two's-complement result with FRAC_BITS fractional bits.
out_valid  output  1  high when normalized_vector holds a result computed from a sampled input.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, all normalized_vector elements go to 0 and out_valid goes to 0. Reset asserted mid-stream discards the in-flight result at that edge.
- Every rising edge with rst=0 samples input_vector and registers its result. The output is valid after that edge: latency 1 cycle, throughput 1 vector per cycle. out_valid=1 from the first non-reset edge onward.
- All arithmetic is combinational between input and output register, at full internal precision:
  - sum = Σx_i, width DATA_WIDTH+log2(N).
  - mean = floor(sum/N), computed by shift.
  - d_i = x_i - mean, signed, width DATA_WIDTH+1.
  - var = floor(Σd_i² / N); squares are 2*(DATA_WIDTH+1) bits, the accumulator adds log2(N) bits.
  - std = floor(sqrt(var)), exact integer square root (restoring/bitwise algorithm).
  - y_i = (d_i << FRAC_BITS) / std, signed division truncated toward zero.
- Saturation: y_i clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before registering.
- Zero std (std==0, e.g. all elements equal): every output element is 0; no divide is performed.
- Inputs are treated as unsigned in all cases; no X-propagation handling is required beyond reset.

Optional Feature:
Macro LAYERNORM_ROUND_NEAREST_EN.
- Defined: the division y_i rounds to nearest, with ties away from zero. Implement as (|d_i|<<FRAC_BITS + std/2)/std, then reapply the sign of d_i, then saturate.
- Undefined: truncation toward zero as specified above.
- Latency, ports and the zero-std rule are identical in both builds.

Test Plan:
- rst=1 for 2 cycles with any input -> all normalized_vector=0, out_valid=0; release rst -> out_valid=1 after the next edge.
- Input {10,20,30,40}, one edge -> mean 25, var 125, std 11; output {-21,-7,7,21} (unsigned display 235,249,7,21). With LAYERNORM_ROUND_NEAREST_EN: {-22,-7,7,22}.
- Input {50,50,50,50} -> std 0 -> output {0,0,0,0}, out_valid=1.
- Input {0,0,0,255} -> mean 63, d {-63,-63,-63,192}, var 12192, std 110 -> output {-9,-9,-9,27}.
- Back-to-back inputs {10,20,30,40} then {40,30,20,10} on consecutive edges -> outputs {-21,-7,7,21} then {21,7,-7,-21}, one per cycle, no bubbles.
- Assert rst for one edge while streaming -> that cycle outputs 0 and out_valid=0; the next non-reset edge produces the correct result for the input present then.
